// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/interrupt/MRET sequencer producing CSR update data and fetch redirects
module trap_ctrl #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic [5:0]  exc_i,
    input  logic [31:0] tval_i,
    input  logic        mret_i,
    input  logic [2:0]  irq_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic [31:0] mstatus_o,
    output logic [31:0] mip_o,
    output logic        is_int_o,
    output logic        redirect_o,
    output logic [31:0] target_pc_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        REDIR = 2'd2,
        RET   = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] mcause_q, mepc_q, mtval_q, mstatus_q, mip_q;
    logic        is_int_q;

    logic        take_int, take_exc, take_ret;
    logic [3:0]  int_code;
    logic [3:0]  exc_cause;
    logic        exc_has_tval;
    logic [2:0]  irq_hit;

    logic unused_bits;
    assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mepc_i[1:0]};

    // Ordered MEI, MSI, MTI so a plain priority scan gives the required precedence.
    assign irq_hit = {irq_i[2] & mie_i[11], irq_i[0] & mie_i[3], irq_i[1] & mie_i[7]}
                     & {3{mstatus_q[3]}};

    always_comb begin
        int_code = 4'd7;
        if (irq_hit[2])
            int_code = 4'd11;
        else if (irq_hit[1])
            int_code = 4'd3;
    end

    always_comb begin
        exc_cause    = 4'd0;
        exc_has_tval = 1'b0;
        if (exc_i[0]) begin
            exc_cause    = 4'd0;
            exc_has_tval = 1'b1;
        end else if (exc_i[1]) begin
            exc_cause    = 4'd2;
            exc_has_tval = 1'b1;
        end else if (exc_i[3]) begin
            exc_cause    = 4'd3;
        end else if (exc_i[2]) begin
            exc_cause    = 4'd11;
        end else if (exc_i[4]) begin
            exc_cause    = 4'd4;
            exc_has_tval = 1'b1;
        end else if (exc_i[5]) begin
            exc_cause    = 4'd6;
            exc_has_tval = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        take_int   = 1'b0;
        take_exc   = 1'b0;
        take_ret   = 1'b0;
        case (state)
            IDLE: begin
                if (inst_valid_i) begin
                    if (|irq_hit) begin
                        take_int   = 1'b1;
                        state_next = TRAP;
                    end else if (|exc_i) begin
                        take_exc   = 1'b1;
                        state_next = TRAP;
                    end else if (mret_i) begin
                        take_ret   = 1'b1;
                        state_next = RET;
                    end
                end
            end
            TRAP:    state_next = REDIR;
            REDIR:   state_next = IDLE;
            RET:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mstatus is updated on the capture edge so the new value accompanies the strobe/redirect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mcause_q  <= 32'd0;
            mepc_q    <= 32'd0;
            mtval_q   <= 32'd0;
            mstatus_q <= 32'h0000_1800;
            mip_q     <= 32'd0;
            is_int_q  <= 1'b0;
        end else begin
            state <= state_next;
            mip_q <= {20'd0, irq_i[2], 3'd0, irq_i[1], 3'd0, irq_i[0], 3'd0};
            if (take_int || take_exc) begin
                mcause_q  <= take_int ? {1'b1, 27'd0, int_code} : {28'd0, exc_cause};
                mepc_q    <= pc_i;
                mtval_q   <= (take_exc && exc_has_tval) ? tval_i : 32'd0;
                is_int_q  <= take_int;
                mstatus_q <= {mstatus_q[31:13], 2'b11, mstatus_q[10:8], mstatus_q[3],
                              mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
            end else if (take_ret) begin
                mstatus_q <= {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7],
                              mstatus_q[2:0]};
            end
        end
    end

    always_comb begin
        target_pc_o = 32'd0;
        if (state == REDIR) begin
            target_pc_o = {mtvec_i[31:2], 2'b00};
            if (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && is_int_q)
                target_pc_o = {mtvec_i[31:2], 2'b00} + {26'd0, mcause_q[3:0], 2'b00};
        end else if (state == RET) begin
            target_pc_o = {mepc_i[31:2], 2'b00};
        end
    end

    assign we_exc_o   = (state == TRAP);
    assign redirect_o = (state == REDIR) || (state == RET);
    assign stall_o    = (state != IDLE);
    assign mcause_o   = mcause_q;
    assign mepc_o     = mepc_q;
    assign mtval_o    = mtval_q;
    assign mstatus_o  = mstatus_q;
    assign mip_o      = mip_q;
    assign is_int_o   = is_int_q;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter VECTORED_EN, default 1: when 1, mtvec mode 1 (vectored) is honoured for interrupts; when 0, mtvec[1:0] is ignored.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 inst_valid_i  in  1  an instruction at pc_i is retiring this cycle.
REQ-005 pc_i  in  32  PC of the retiring instruction.
REQ-006 exc_i  in  6  exception flags: [0] inst-addr-misaligned, [1] illegal, [2] ecall, [3] ebreak, [4] load-misaligned, [5] store-misaligned.
REQ-007 tval_i  in  32  faulting address or instruction word that accompanies exc_i.
REQ-008 mret_i  in  1  retiring instruction is MRET.
REQ-009 irq_i  in  3  pending lines: [0] software (MSIP), [1] timer (MTIP), [2] external (MEIP).
REQ-010 mie_i, mtvec_i, mepc_i  in  32 each  current CSR values.
REQ-011 we_exc_o  out  1  one-cycle write strobe for mcause/mepc/mtval.
REQ-012 mcause_o, mepc_o, mtval_o, mstatus_o, mip_o  out  32 each  CSR update data.
REQ-013 is_int_o  out  1  the trap being written is an interrupt.
REQ-014 redirect_o  out  1  one-cycle fetch redirect; target on target_pc_o (out 32).
REQ-015 stall_o  out  1  pipeline hold while the FSM is not IDLE.

Function
REQ-016 FSM states are IDLE, TRAP, REDIR and RET.
REQ-017 Interrupt eligible: mstatus_o[3] (MIE)=1 and irq_i[k] & mie_i[bit k] with bits 3/7/11; priority MEI(11) > MSI(3) > MTI(7).
REQ-018 Exception priority, highest first: exc_i[0] cause 0, [1] cause 2, [3] cause 3, [2] cause 11, [4] cause 4, [5] cause 6.
REQ-019 In IDLE with inst_valid_i=1, the highest-priority source is chosen: eligible interrupt > exception > mret_i; with no source the FSM stays in IDLE.
REQ-020 On an interrupt capture: mcause_o={1,27'b0,code}, mepc_o=pc_i, mtval_o=0, is_int_o=1; next state TRAP.
REQ-021 On an exception capture: mcause_o=cause, mepc_o=pc_i, mtval_o=tval_i for causes 0/2/4/6 and 0 otherwise; is_int_o=0; next state TRAP.
REQ-022 In TRAP: we_exc_o=1 for exactly this cycle; mstatus_o MPIE[7]<=MIE[3], MIE<=0, MPP[12:11]<=2'b11; next state REDIR.
REQ-023 In REDIR: redirect_o=1; target_pc_o={mtvec_i[31:2],2'b00}, plus 4*code when VECTORED_EN=1, mtvec_i[1:0]=01 and is_int_o=1; next state IDLE.
REQ-024 On an MRET capture the next state is RET; in RET: redirect_o=1, target_pc_o={mepc_i[31:2],2'b00}, MIE<=MPIE, MPIE<=1, MPP unchanged, we_exc_o=0; next state IDLE.
REQ-025 mip_o={20'b0,irq_i[2],3'b0,irq_i[1],3'b0,irq_i[0],3'b0}, registered every cycle regardless of state.
REQ-026 stall_o=1 in TRAP, REDIR and RET; inputs other than irq_i are ignored outside IDLE.
REQ-027 Latency: capture edge to we_exc_o is 1 cycle, and to redirect_o is 2 cycles; MRET capture to redirect_o is 1 cycle.
REQ-028 An exception on an MRET instruction takes precedence over the MRET, which is discarded.
REQ-029 Back-to-back traps: a source present on the first IDLE cycle after REDIR or RET is captured normally.

Reset
REQ-030 Asserting rst_i at any time, including mid-sequence, forces IDLE immediately.
REQ-031 Reset values: mstatus_o=0x00001800; mcause_o, mepc_o, mtval_o, mip_o and target_pc_o =0; we_exc_o, redirect_o, stall_o and is_int_o =0.
REQ-032 No trap is taken while rst_i=1; the first capture is possible on the first edge after deassertion.

Verification
REQ-033 Illegal instruction: exc_i[1]=1, pc_i=0x100, tval_i=0x0000FFFF -> next cycle we_exc_o=1 with mcause_o=2, mepc_o=0x100, mtval_o=0xFFFF; following cycle redirect_o=1 with target_pc_o=mtvec_i.
REQ-034 Vectored timer interrupt: mtvec_i=0x201, MIE=1, mie_i[7]=1, irq_i=3'b010 -> mcause_o=0x80000007, target_pc_o=0x21C, mtval_o=0.
REQ-035 Priority: irq_i=3'b111 with all enables set and exc_i[2]=1 -> mcause_o=0x8000000B; exc_i=6'b000110 with no irq -> mcause_o=2.
REQ-036 MRET after a trap: mstatus_o=0x1880, mepc_i=0x400 -> RET cycle redirect_o=1, target_pc_o=0x400, mstatus_o=0x1888, we_exc_o=0.
REQ-037 Masking: MIE=0, irq_i=3'b100, mie_i[11]=1 -> no trap taken and stall_o stays 0; mip_o=0x800.
REQ-038 Reset in TRAP: rst_i pulsed while we_exc_o=1 -> all outputs at reset values, and no redirect_o afterwards.
